// File: rtl/dcache_responder_pkg.sv
// Shared encodings and the FSM state type for the data-cache responder.
// Optional statistics counters are enabled by defining DCACHE_STATS_EN.
package dcache_responder_pkg;

    localparam logic [2:0] MrLb  = 3'b001;
    localparam logic [2:0] MrLh  = 3'b010;
    localparam logic [2:0] MrLw  = 3'b011;
    localparam logic [2:0] MrLbu = 3'b101;
    localparam logic [2:0] MrLhu = 3'b110;

    localparam logic [1:0] MwNone = 2'b00;
    localparam logic [1:0] MwSb   = 2'b01;
    localparam logic [1:0] MwSh   = 2'b10;
    localparam logic [1:0] MwSw   = 2'b11;

    typedef enum logic [1:0] {
        StIdle      = 2'b00,
        StWriteback = 2'b01,
        StAllocate  = 2'b10,
        StFill      = 2'b11
    } state_e;

    // Unlisted MEM_READ codes (100, 111) behave as "no read".
    function automatic logic is_read_op(input logic [2:0] op);
        return op inside {MrLb, MrLh, MrLw, MrLbu, MrLhu};
    endfunction

endpackage

// File: rtl/dcache_responder_if.sv
// CPU request/response and main-memory block bus of the data-cache responder.
// slave = the cache; master = the CPU stage plus main-memory model around it.
interface dcache_responder_if;

    logic [2:0]   MEM_READ;
    logic [1:0]   MEM_WRITE;
    logic [31:0]  ADDRESS;
    logic [31:0]  WRITE_DATA;
    logic [31:0]  READ_DATA;
    logic         BUSYWAIT;
    logic         MAIN_READ;
    logic         MAIN_WRITE;
    logic [27:0]  MAIN_ADDRESS;
    logic [127:0] MAIN_WRITE_DATA;
    logic [127:0] MAIN_READ_DATA;
    logic         MAIN_BUSYWAIT;

    modport slave (
        input  MEM_READ, MEM_WRITE, ADDRESS, WRITE_DATA, MAIN_READ_DATA, MAIN_BUSYWAIT,
        output READ_DATA, BUSYWAIT, MAIN_READ, MAIN_WRITE, MAIN_ADDRESS, MAIN_WRITE_DATA
    );

    modport master (
        output MEM_READ, MEM_WRITE, ADDRESS, WRITE_DATA, MAIN_READ_DATA, MAIN_BUSYWAIT,
        input  READ_DATA, BUSYWAIT, MAIN_READ, MAIN_WRITE, MAIN_ADDRESS, MAIN_WRITE_DATA
    );

endinterface

// File: rtl/dcache_data_align.sv
// Combinational lane logic: selects and extends load bytes/halves from a cache line
// and merges store bytes into a copy of that line.
module dcache_data_align
    import dcache_responder_pkg::*;
(
    input  logic [127:0] line_i,
    input  logic [1:0]   word_i,
    input  logic [1:0]   byte_i,
    input  logic [2:0]   mem_read_i,
    input  logic [1:0]   mem_write_i,
    input  logic [31:0]  write_data_i,
    output logic [31:0]  load_data_o,
    output logic [127:0] line_o
);

    logic [31:0] word;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] new_word;

    always_comb begin
        word     = line_i[{word_i, 5'b0} +: 32];
        sel_byte = word[{byte_i, 3'b0} +: 8];
        // Halfword accesses drop byte_i[0]; word accesses drop byte_i entirely.
        sel_half = word[{byte_i[1], 4'b0} +: 16];

        case (mem_read_i)
            MrLb:    load_data_o = {{24{sel_byte[7]}}, sel_byte};
            MrLh:    load_data_o = {{16{sel_half[15]}}, sel_half};
            MrLw:    load_data_o = word;
            MrLbu:   load_data_o = {24'b0, sel_byte};
            MrLhu:   load_data_o = {16'b0, sel_half};
            default: load_data_o = '0;
        endcase

        new_word = word;
        case (mem_write_i)
            MwSb:    new_word[{byte_i, 3'b0} +: 8] = write_data_i[7:0];
            MwSh:    new_word[{byte_i[1], 4'b0} +: 16] = write_data_i[15:0];
            MwSw:    new_word = write_data_i;
            default: ;
        endcase

        line_o = line_i;
        line_o[{word_i, 5'b0} +: 32] = new_word;
    end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache answering CPU loads/stores.
// Define DCACHE_STATS_EN to add the HIT_COUNT / MISS_COUNT statistics outputs.
module dcache_responder
    import dcache_responder_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 3
) (
    input  logic        CLOCK,
    input  logic        RESET,
`ifdef DCACHE_STATS_EN
    output logic [31:0] HIT_COUNT,
    output logic [31:0] MISS_COUNT,
`endif
    dcache_responder_if.slave bus
);

    localparam int unsigned Sets = 1 << INDEX_BITS;
    localparam int unsigned TagW = 28 - INDEX_BITS;

    state_e state_q, state_d;

    logic [Sets-1:0] valid_q;
    logic [Sets-1:0] dirty_q;
    logic [TagW-1:0] tag_q  [Sets];
    logic [127:0]    data_q [Sets];

    logic [INDEX_BITS-1:0] idx;
    logic [TagW-1:0]       tag;
    logic                  rd_req;
    logic                  wr_req;
    logic                  req;
    logic                  hit;
    logic [127:0]          line;
    logic [127:0]          merged_line;
    logic [31:0]           load_data;
    logic                  fill_en;
    logic                  store_en;

    assign idx    = bus.ADDRESS[3+INDEX_BITS:4];
    assign tag    = bus.ADDRESS[31:4+INDEX_BITS];
    assign rd_req = is_read_op(bus.MEM_READ);
    assign wr_req = (bus.MEM_WRITE != MwNone);
    assign req    = rd_req | wr_req;
    assign line   = data_q[idx];
    assign hit    = valid_q[idx] && (tag_q[idx] == tag);

    assign bus.MAIN_WRITE_DATA = line;

    dcache_data_align u_align (
        .line_i       (line),
        .word_i       (bus.ADDRESS[3:2]),
        .byte_i       (bus.ADDRESS[1:0]),
        .mem_read_i   (bus.MEM_READ),
        .mem_write_i  (bus.MEM_WRITE),
        .write_data_i (bus.WRITE_DATA),
        .load_data_o  (load_data),
        .line_o       (merged_line)
    );

    always_comb begin
        state_d          = state_q;
        bus.BUSYWAIT     = 1'b0;
        bus.READ_DATA    = '0;
        bus.MAIN_READ    = 1'b0;
        bus.MAIN_WRITE   = 1'b0;
        bus.MAIN_ADDRESS = bus.ADDRESS[31:4];
        fill_en          = 1'b0;
        store_en         = 1'b0;

        case (state_q)
            StIdle: begin
                if (req) begin
                    if (hit) begin
                        store_en = wr_req;
                        // A simultaneous store wins, so the load result is suppressed.
                        if (!wr_req) bus.READ_DATA = load_data;
                    end else begin
                        bus.BUSYWAIT = 1'b1;
                        state_d      = dirty_q[idx] ? StWriteback : StAllocate;
                    end
                end
            end
            StWriteback: begin
                bus.BUSYWAIT     = 1'b1;
                bus.MAIN_WRITE   = 1'b1;
                bus.MAIN_ADDRESS = {tag_q[idx], idx};
                if (!bus.MAIN_BUSYWAIT) state_d = StAllocate;
            end
            StAllocate: begin
                bus.BUSYWAIT  = 1'b1;
                bus.MAIN_READ = 1'b1;
                if (!bus.MAIN_BUSYWAIT) state_d = StFill;
            end
            StFill: begin
                bus.BUSYWAIT = 1'b1;
                fill_en      = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Outputs go quiet the instant reset rises, not at the next edge.
        if (RESET) begin
            bus.BUSYWAIT   = 1'b0;
            bus.READ_DATA  = '0;
            bus.MAIN_READ  = 1'b0;
            bus.MAIN_WRITE = 1'b0;
            fill_en        = 1'b0;
            store_en       = 1'b0;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (fill_en) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (store_en) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage need no reset; valid bits gate their use.
    always_ff @(posedge CLOCK) begin
        if (fill_en) begin
            data_q[idx] <= bus.MAIN_READ_DATA;
            tag_q[idx]  <= tag;
        end else if (store_en) begin
            data_q[idx] <= merged_line;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;
    logic        retry_q;

    // retry_q marks the IDLE cycle right after a fill, whose hit is the replay of a counted miss.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
            retry_q      <= 1'b0;
        end else begin
            retry_q <= (state_q == StFill);
            if ((state_q == StIdle) && req && !retry_q) begin
                if (hit) hit_count_q <= hit_count_q + 32'd1;
                else     miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign HIT_COUNT  = hit_count_q;
    assign MISS_COUNT = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Directed plus randomized bench for dcache_responder against a flat-memory reference model.
module tb_dcache_responder;

    logic clk;
    logic rst;

    dcache_responder_if bus ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    dcache_responder #(.INDEX_BITS(3)) dut (
        .CLOCK      (clk),
        .RESET      (rst),
`ifdef DCACHE_STATS_EN
        .HIT_COUNT  (hit_count),
        .MISS_COUNT (miss_count),
`endif
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Main-memory model and transaction logs.
    logic [127:0] mem_arr [logic [27:0]];
    logic [27:0]  wr_log_addr [$];
    logic [127:0] wr_log_data [$];
    logic [27:0]  rd_log [$];
    int           mem_lat = 0;
    int           mem_cnt = -1;

    // Reference: CPU-visible memory, main-memory image and which block each set holds.
    logic [127:0] cpu_blk  [logic [27:0]];
    logic [127:0] ref_main [logic [27:0]];
    logic         res_valid [8];
    logic         res_dirty [8];
    logic [24:0]  res_tag   [8];
    int           exp_hits = 0;
    int           exp_misses = 0;

    function automatic logic [127:0] init_blk(input logic [27:0] b);
        logic [127:0] r;
        for (int i = 0; i < 4; i++)
            r[32*i +: 32] = ({4'h0, b} * 32'h9E37_79B1) ^ (32'h0101_0101 * (i + 1));
        return r;
    endfunction

    always @(negedge clk) begin
        if (bus.MAIN_READ === 1'b1 || bus.MAIN_WRITE === 1'b1) begin
            if (mem_cnt < 0) begin
                mem_cnt = mem_lat;
                bus.MAIN_BUSYWAIT = 1'b1;
            end
            if (mem_cnt == 0) begin
                if (bus.MAIN_WRITE === 1'b1) begin
                    mem_arr[bus.MAIN_ADDRESS] = bus.MAIN_WRITE_DATA;
                    wr_log_addr.push_back(bus.MAIN_ADDRESS);
                    wr_log_data.push_back(bus.MAIN_WRITE_DATA);
                end else begin
                    if (!mem_arr.exists(bus.MAIN_ADDRESS))
                        mem_arr[bus.MAIN_ADDRESS] = init_blk(bus.MAIN_ADDRESS);
                    bus.MAIN_READ_DATA = mem_arr[bus.MAIN_ADDRESS];
                    rd_log.push_back(bus.MAIN_ADDRESS);
                end
                bus.MAIN_BUSYWAIT = 1'b0;
                mem_cnt = -1;
            end else begin
                mem_cnt--;
            end
        end else begin
            bus.MAIN_BUSYWAIT = 1'b0;
            mem_cnt = -1;
        end
    end

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic preload(input logic [27:0] b, input logic [127:0] d);
        mem_arr[b]  = d;
        cpu_blk[b]  = d;
        ref_main[b] = d;
    endtask

    task automatic ref_reset();
        logic [27:0] b;
        for (int s = 0; s < 8; s++) begin
            // Dirty data never reached main memory, so it is lost.
            if (res_valid[s] && res_dirty[s]) begin
                b = {res_tag[s], 3'(s)};
                cpu_blk[b] = ref_main[b];
            end
            res_valid[s] = 1'b0;
            res_dirty[s] = 1'b0;
        end
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic ref_access(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic miss, output logic wb,
                              output logic [27:0] wb_blk, output logic [127:0] wb_data,
                              output logic [31:0] rdata);
        logic [27:0]  b;
        logic [127:0] blk;
        logic         is_rd;
        logic         is_wr;
        int           s;
        int           n;
        int unsigned  base;
        int unsigned  off;
        b = addr[31:4];
        s = int'(addr[6:4]);
        is_rd = rd inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
        is_wr = (wr != 2'd0);
        miss = 1'b0; wb = 1'b0; wb_blk = '0; wb_data = '0; rdata = '0;
        if (!is_rd && !is_wr) return;
        if (!cpu_blk.exists(b)) begin
            cpu_blk[b]  = init_blk(b);
            ref_main[b] = init_blk(b);
        end
        if (!(res_valid[s] && res_tag[s] == addr[31:7])) begin
            miss = 1'b1;
            if (res_valid[s] && res_dirty[s]) begin
                wb = 1'b1;
                wb_blk = {res_tag[s], addr[6:4]};
                wb_data = cpu_blk[wb_blk];
                ref_main[wb_blk] = wb_data;
            end
            res_valid[s] = 1'b1;
            res_tag[s]   = addr[31:7];
            res_dirty[s] = 1'b0;
        end
        blk = cpu_blk[b];
        if (is_wr) begin
            n = (wr == 2'd1) ? 1 : (wr == 2'd2) ? 2 : 4;
            base = addr & ~(n - 1);
            for (int k = 0; k < n; k++) begin
                off = (base + k) % 16;
                blk[8*off +: 8] = wdata[8*k +: 8];
            end
            cpu_blk[b] = blk;
            res_dirty[s] = 1'b1;
        end else begin
            n = (rd == 3'd1 || rd == 3'd5) ? 1 : (rd == 3'd3) ? 4 : 2;
            base = addr & ~(n - 1);
            for (int k = 0; k < n; k++) begin
                off = (base + k) % 16;
                rdata[8*k +: 8] = blk[8*off +: 8];
            end
            if (rd == 3'd1 && rdata[7])  rdata = rdata | 32'hFFFF_FF00;
            if (rd == 3'd2 && rdata[15]) rdata = rdata | 32'hFFFF_0000;
        end
        if (miss) exp_misses++;
        else      exp_hits++;
    endtask

    // Called at negedge+1; returns at the next negedge+1 after the hit cycle's edge.
    task automatic do_access(input string name, input logic [2:0] rd, input logic [1:0] wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] obs_rd);
        logic         e_miss;
        logic         e_wb;
        logic [27:0]  e_wb_blk;
        logic [127:0] e_wb_data;
        logic [31:0]  e_rd;
        logic         o_miss;
        int           cyc;
        ref_access(rd, wr, addr, wdata, e_miss, e_wb, e_wb_blk, e_wb_data, e_rd);
        wr_log_addr.delete();
        wr_log_data.delete();
        rd_log.delete();
        bus.MEM_READ   = rd;
        bus.MEM_WRITE  = wr;
        bus.ADDRESS    = addr;
        bus.WRITE_DATA = wdata;
        #1;
        o_miss = bus.BUSYWAIT;
        cyc = 0;
        while (bus.BUSYWAIT !== 1'b0 && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check({name, " timeout"}, (cyc < 200), 1'b1);
        obs_rd = bus.READ_DATA;
        check({name, " stall"}, o_miss, e_miss);
        check({name, " rdata"}, obs_rd, e_rd);
        check({name, " wb count"}, wr_log_addr.size(), e_wb);
        if (e_wb && wr_log_addr.size() > 0) begin
            check({name, " wb addr"}, wr_log_addr[0], e_wb_blk);
            check({name, " wb data"}, wr_log_data[0], e_wb_data);
        end
        check({name, " fill count"}, rd_log.size(), e_miss);
        if (e_miss && rd_log.size() > 0) check({name, " fill addr"}, rd_log[0], addr[31:4]);
        @(negedge clk);
        #1;
        bus.MEM_READ  = 3'd0;
        bus.MEM_WRITE = 2'd0;
    endtask

    logic [31:0] r;
    logic        e_m;
    logic        e_w;
    logic [27:0] e_b;
    logic [127:0] e_d;
    logic [31:0] e_r;
    int          cyc5;
    int          kind;
    logic [2:0]  ld_codes [5];

    initial begin
        ld_codes = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
        rst = 1'b1;
        bus.MEM_READ = 3'd3;
        bus.MEM_WRITE = 2'd0;
        bus.ADDRESS = 32'h40;
        bus.WRITE_DATA = '0;
        bus.MAIN_READ_DATA = '0;
        bus.MAIN_BUSYWAIT = 1'b0;
        ref_reset();
        preload(28'h4, {32'hA0A0_A0A3, 32'hA0A0_A0A2, 32'h8177_5566, 32'h1122_3344});
        repeat (2) @(negedge clk);
        #1;
        check("reset busywait", bus.BUSYWAIT, 1'b0);
        check("reset read_data", bus.READ_DATA, 32'h0);
        check("reset main_read", bus.MAIN_READ, 1'b0);
        check("reset main_write", bus.MAIN_WRITE, 1'b0);
        bus.MEM_READ = 3'd0;
        @(negedge clk);
        rst = 1'b0;
        #1;

        mem_lat = 2;
        do_access("t1 cold lw", 3'd3, 2'd0, 32'h40, 32'h0, r);
        check("t1 lw value", r, 32'h1122_3344);
        check("t1 fill block", rd_log[0], 28'h4);

        do_access("t2 lb", 3'd1, 2'd0, 32'h41, 32'h0, r);
        check("t2 lb value", r, 32'h0000_0033);
        do_access("t2 lbu", 3'd5, 2'd0, 32'h43, 32'h0, r);
        check("t2 lbu value", r, 32'h0000_0011);
        do_access("t2 lh", 3'd2, 2'd0, 32'h46, 32'h0, r);
        check("t2 lh value", r, 32'hFFFF_8177);

        do_access("t3 sb", 3'd0, 2'd1, 32'h40, 32'h0000_00AB, r);
        do_access("t3 lw", 3'd3, 2'd0, 32'h40, 32'h0, r);
        check("t3 lw value", r, 32'h1122_33AB);
        check("t3 no main", wr_log_addr.size() + rd_log.size(), 0);

        do_access("t4 evict lw", 3'd3, 2'd0, 32'hC0, 32'h0, r);
        check("t4 wb block", wr_log_addr[0], 28'h4);
        check("t4 wb word0", wr_log_data[0][31:0], 32'h1122_33AB);
        check("t4 fill block", rd_log[0], 28'hC);
`ifdef DCACHE_STATS_EN
        check("t6 hit count", hit_count, 32'd5);
        check("t6 miss count", miss_count, 32'd2);
`endif

        do_access("t6 read+write", 3'd3, 2'd3, 32'hC4, 32'hDEAD_BEEF, r);
        check("t6 write wins rdata", r, 32'h0);
        do_access("t6 readback", 3'd3, 2'd0, 32'hC4, 32'h0, r);
        check("t6 readback value", r, 32'hDEAD_BEEF);

        // Reset while ALLOCATE is waiting on a busy memory.
        mem_lat = 8;
        ref_access(3'd3, 2'd0, 32'h40, 32'h0, e_m, e_w, e_b, e_d, e_r);
        wr_log_addr.delete();
        wr_log_data.delete();
        rd_log.delete();
        bus.MEM_READ = 3'd3;
        bus.ADDRESS = 32'h40;
        cyc5 = 0;
        while (bus.MAIN_READ !== 1'b1 && cyc5 < 100) begin
            @(negedge clk);
            #1;
            cyc5++;
        end
        check("t5 allocate reached", bus.MAIN_READ, 1'b1);
        check("t5 wb before alloc", wr_log_addr.size(), 1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t5 main_read drop", bus.MAIN_READ, 1'b0);
        check("t5 main_write low", bus.MAIN_WRITE, 1'b0);
        check("t5 busywait low", bus.BUSYWAIT, 1'b0);
        check("t5 read_data zero", bus.READ_DATA, 32'h0);
        ref_reset();
        bus.MEM_READ = 3'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        mem_lat = 1;
        do_access("t5 relw", 3'd3, 2'd0, 32'h40, 32'h0, r);
        check("t5 relw value", r, 32'h1122_33AB);

        // Randomized mix over 64 blocks sharing 8 sets.
        for (int i = 0; i < 120; i++) begin
            mem_lat = $urandom_range(0, 3);
            kind = $urandom_range(0, 10);
            if (kind <= 4)
                do_access("rnd load", ld_codes[$urandom_range(0, 4)], 2'd0,
                          $urandom_range(0, 1023), 32'h0, r);
            else if (kind <= 8)
                do_access("rnd store", 3'd0, 2'($urandom_range(1, 3)),
                          $urandom_range(0, 1023), $urandom(), r);
            else if (kind == 9)
                do_access("rnd both", ld_codes[$urandom_range(0, 4)], 2'($urandom_range(1, 3)),
                          $urandom_range(0, 1023), $urandom(), r);
            else
                do_access("rnd none", ($urandom_range(0, 1) == 0) ? 3'd4 : 3'd7, 2'd0,
                          $urandom_range(0, 1023), 32'h0, r);
        end
`ifdef DCACHE_STATS_EN
        check("final hit count", hit_count, exp_hits);
        check("final miss count", miss_count, exp_misses);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
